// File: rtl/noobs_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding, address-space
// select bits and default bus widths.
package noobs_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned CNT_W      = 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACK_I = 2'd1;
   localparam logic [1:0] ACK_D = 2'd2;

   localparam logic SPACE_I = 1'b0;
   localparam logic SPACE_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU instruction/data ports plus the SRAM macro side of the memory arbiter.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = noobs_mem_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_W = noobs_mem_pkg::DATA_W_DEF
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_data;
   logic              i_ack;
   logic              d_en;
   logic              d_rd;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wr_data;
   logic [DATA_W-1:0] d_rd_data;
   logic              d_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W:0]   mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              err_conflict;

   modport slave (
      input  i_req, i_addr, d_en, d_rd, d_wr, d_addr, d_wr_data, mem_rdata,
      output i_data, i_ack, d_rd_data, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
             err_conflict
   );

   modport master (
      output i_req, i_addr, d_en, d_rd, d_wr, d_addr, d_wr_data, mem_rdata,
      input  i_data, i_ack, d_rd_data, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
             err_conflict
   );
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive data-port wins while an instruction fetch waits; asserts
// override_c once the fetch has lost MAX_WAIT times in a row.
module mem_arb_starve_cnt
   import noobs_mem_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset_,
   input  logic in_idle,
   input  logic i_req,
   input  logic grant_i,
   input  logic grant_d,
   output logic override_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt;

   // Only issue cycles move the counter; ack cycles hold it.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wait_cnt <= '0;
      end else if (in_idle) begin
         if (!i_req || grant_i) begin
            wait_cnt <= '0;
         end else if (grant_d && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   assign override_c = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 8K x 8 SRAM between the instruction-fetch and data
// ports: data has priority, instruction fetch has a bounded wait.
module mem_arbiter
   import noobs_mem_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic         clk,
   input  logic         reset_,
   mem_arbiter_if.slave bus
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              grant_i;
   logic              grant_d;
   logic              in_idle;
   logic              override_c;
   logic              i_ack_q;
   logic              d_ack_q;
   logic              err_q;
   logic [ADDR_W:0]   addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign in_idle = (state == IDLE);

   mem_arb_starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_cnt (
      .clk        (clk),
      .reset_     (reset_),
      .in_idle    (in_idle),
      .i_req      (bus.i_req),
      .grant_i    (grant_i),
      .grant_d    (grant_d),
      .override_c (override_c)
   );

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant only from IDLE so a request still held during its ack is not re-issued.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_req && (!bus.d_en || override_c)) begin
               grant_i   = 1'b1;
               state_nxt = ACK_I;
            end else if (bus.d_en) begin
               grant_d   = 1'b1;
               state_nxt = ACK_D;
            end
         end
         ACK_I:   state_nxt = IDLE;
         ACK_D:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         i_ack_q <= grant_i;
         d_ack_q <= grant_d;
         if (grant_d && bus.d_rd && bus.d_wr) begin
            err_q <= 1'b1;
         end
         if (grant_i) begin
            addr_q <= {SPACE_I, bus.i_addr};
         end else if (grant_d) begin
            addr_q  <= {SPACE_D, bus.d_addr};
            wdata_q <= bus.d_wr_data;
         end
      end
   end

   // A read/write conflict executes as a read so the requester still gets its ack.
   assign bus.mem_en       = reset_ & (grant_i | grant_d);
   assign bus.mem_we       = reset_ & grant_d & bus.d_wr & ~bus.d_rd;
   assign bus.mem_addr     = grant_i ? {SPACE_I, bus.i_addr} :
                             grant_d ? {SPACE_D, bus.d_addr} : addr_q;
   assign bus.mem_wdata    = grant_d ? bus.d_wr_data : wdata_q;
   assign bus.i_data       = bus.mem_rdata;
   assign bus.d_rd_data    = bus.mem_rdata;
   assign bus.i_ack        = i_ack_q;
   assign bus.d_ack        = d_ack_q;
   assign bus.err_conflict = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model with a shadow SRAM.
module tb_mem_arbiter;
   import noobs_mem_pkg::*;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;
   localparam int unsigned MW = 4;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus.slave)
   );

   logic [7:0] sram    [0:8191];
   logic [7:0] ref_mem [0:8191];

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= sram[bus.mem_addr];
      end
   end

   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clr_in();
      bus.i_req     = 1'b0;
      bus.i_addr    = '0;
      bus.d_en      = 1'b0;
      bus.d_rd      = 1'b0;
      bus.d_wr      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wr_data = '0;
   endtask

   typedef struct {
      logic        i_req;
      logic [11:0] i_addr;
      logic        d_en, d_rd, d_wr;
      logic [11:0] d_addr;
      logic [7:0]  d_wdata;
      logic        e_en, e_we;
      logic [12:0] e_addr;
      logic        e_iack, e_dack;
      logic [7:0]  e_data;
   } vec_t;

   vec_t vecs [8];
   int   exp_order [10];
   int   gq [$];
   int   first_ack;
   logic prev_ack;
   logic [11:0] b2b_addr [4];

   // Random-run model state
   int          busy, losses, op;
   logic        i_pend, d_pend, issue, win_i, e_we;
   logic [12:0] e_addr;
   logic        ack_i_cur, ack_d_cur, ack_i_nxt, ack_d_nxt;
   logic        chk_rd_cur, chk_rd_nxt, err_cur, err_nxt;
   logic [7:0]  exp_rd_cur, exp_rd_nxt;

   initial begin
      for (int a = 0; a < 8192; a++) begin
         sram[a]    = 8'(a * 7 + 3);
         ref_mem[a] = 8'(a * 7 + 3);
      end
      sram[13'h0010] = 8'hA5;  ref_mem[13'h0010] = 8'hA5;
      sram[13'h1005] = 8'h3C;  ref_mem[13'h1005] = 8'h3C;
      sram[13'h0FFF] = 8'h77;  ref_mem[13'h0FFF] = 8'h77;

      vecs[0] = '{1'b1, 12'h010, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 13'h0010, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h3FF, 8'h5C, 1'b1, 1'b1, 13'h13FF, 1'b0, 1'b1, 8'h00};
      vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h3FF, 8'h00, 1'b1, 1'b0, 13'h13FF, 1'b0, 1'b1, 8'h5C};
      vecs[3] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h005, 8'h00, 1'b1, 1'b0, 13'h1005, 1'b0, 1'b1, 8'h3C};
      vecs[4] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 8'h00};
      vecs[5] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 13'h0FFF, 1'b1, 1'b0, 8'h77};
      vecs[6] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000, 8'hE1, 1'b1, 1'b1, 13'h1000, 1'b0, 1'b1, 8'h00};
      vecs[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 13'h1000, 1'b0, 1'b1, 8'hE1};
      exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      b2b_addr  = '{12'h000, 12'h001, 12'h800, 12'hFFF};

      // Reset: everything quiet, mem_en forced low even with a request present
      reset_ = 1'b0;
      clr_in();
      bus.d_en = 1'b1;
      bus.d_rd = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_i_ack", bus.i_ack, 0);
      chk("rst_d_ack", bus.d_ack, 0);
      chk("rst_err", bus.err_conflict, 0);
      clr_in();
      reset_ = 1'b1;

      // Directed single-transaction vectors
      for (int v = 0; v < 8; v++) begin
         @(posedge clk); #1;
         bus.i_req     = vecs[v].i_req;
         bus.i_addr    = vecs[v].i_addr;
         bus.d_en      = vecs[v].d_en;
         bus.d_rd      = vecs[v].d_rd;
         bus.d_wr      = vecs[v].d_wr;
         bus.d_addr    = vecs[v].d_addr;
         bus.d_wr_data = vecs[v].d_wdata;
         @(negedge clk);
         chk($sformatf("vec%0d_mem_en", v), bus.mem_en, vecs[v].e_en);
         chk($sformatf("vec%0d_mem_we", v), bus.mem_we, vecs[v].e_we);
         if (vecs[v].e_en) chk($sformatf("vec%0d_mem_addr", v), bus.mem_addr, vecs[v].e_addr);
         if (vecs[v].e_we) chk($sformatf("vec%0d_mem_wdata", v), bus.mem_wdata, vecs[v].d_wdata);
         if (vecs[v].e_we) ref_mem[vecs[v].e_addr] = vecs[v].d_wdata;
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("vec%0d_i_ack", v), bus.i_ack, vecs[v].e_iack);
         chk($sformatf("vec%0d_d_ack", v), bus.d_ack, vecs[v].e_dack);
         if (vecs[v].e_iack) chk($sformatf("vec%0d_i_data", v), bus.i_data, vecs[v].e_data);
         if (vecs[v].e_dack && !vecs[v].e_we) chk($sformatf("vec%0d_d_rd_data", v), bus.d_rd_data, vecs[v].e_data);
         chk($sformatf("vec%0d_err", v), bus.err_conflict, 0);
      end
      @(posedge clk); #1;
      clr_in();
      repeat (2) @(posedge clk);
      #1;

      // Starvation bound: both ports held continuously for 20 cycles
      bus.i_req  = 1'b1;
      bus.i_addr = 12'h123;
      bus.d_en   = 1'b1;
      bus.d_rd   = 1'b1;
      bus.d_addr = 12'h0AB;
      first_ack  = 0;
      prev_ack   = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus.mem_en) gq.push_back(int'(bus.mem_addr[12]));
         if (bus.i_ack && first_ack == 0) first_ack = c;
         if (prev_ack && (bus.i_ack || bus.d_ack)) chk("starve_no_consec_ack", 1, 0);
         prev_ack = bus.i_ack | bus.d_ack;
      end
      chk("starve_grants", 32'(gq.size()), 10);
      for (int g = 0; g < 10 && g < gq.size(); g++)
         chk($sformatf("starve_grant%0d", g), 32'(gq[g]), 32'(exp_order[g]));
      chk("starve_first_i_ack_cycle", 32'(first_ack), 10);
      @(posedge clk); #1;
      clr_in();
      repeat (2) @(posedge clk);
      #1;

      // Conflict: executed as a read, acked, sticky error
      bus.d_en = 1'b1; bus.d_rd = 1'b1; bus.d_wr = 1'b1;
      bus.d_addr = 12'h020; bus.d_wr_data = 8'h99;
      @(negedge clk);
      chk("conf_mem_en", bus.mem_en, 1);
      chk("conf_mem_we", bus.mem_we, 0);
      chk("conf_mem_addr", bus.mem_addr, 13'h1020);
      @(posedge clk); #1;
      @(negedge clk);
      chk("conf_d_ack", bus.d_ack, 1);
      chk("conf_rd_data", bus.d_rd_data, ref_mem[13'h1020]);
      chk("conf_err", bus.err_conflict, 1);
      @(posedge clk); #1;
      bus.d_rd = 1'b0; bus.d_addr = 12'h021; bus.d_wr_data = 8'h42;
      @(negedge clk);
      chk("conf_clean_we", bus.mem_we, 1);
      ref_mem[13'h1021] = 8'h42;
      @(posedge clk); #1;
      @(negedge clk);
      chk("conf_clean_ack", bus.d_ack, 1);
      chk("conf_err_sticky", bus.err_conflict, 1);
      @(posedge clk); #1;
      clr_in();
      @(negedge clk);
      chk("conf_err_sticky_idle", bus.err_conflict, 1);

      // Reset pulled in the ACK_D cycle
      @(posedge clk); #1;
      bus.d_en = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 12'h030; bus.d_wr_data = 8'h11;
      ref_mem[13'h1030] = 8'h11;
      @(posedge clk); #1;
      chk("rmid_d_ack_before", bus.d_ack, 1);
      reset_ = 1'b0;
      #1;
      chk("rmid_d_ack", bus.d_ack, 0);
      chk("rmid_mem_en", bus.mem_en, 0);
      chk("rmid_err_cleared", bus.err_conflict, 0);
      clr_in();
      @(negedge clk);
      reset_ = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rmid_quiet_en", bus.mem_en, 0);
         chk("rmid_quiet_ack", bus.i_ack | bus.d_ack, 0);
      end
      @(posedge clk); #1;
      bus.i_req = 1'b1; bus.i_addr = 12'h010;
      @(negedge clk);
      chk("rmid_idle_issue", bus.mem_en, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rmid_idle_ack", bus.i_ack, 1);
      @(posedge clk); #1;
      clr_in();
      repeat (2) @(posedge clk);

      // Back-to-back fetches: new address in the cycle after each ack
      for (int c = 1, k = 0; c <= 8; c++) begin
         @(posedge clk); #1;
         bus.i_req  = 1'b1;
         bus.i_addr = b2b_addr[k];
         @(negedge clk);
         chk($sformatf("b2b_i_ack_c%0d", c), bus.i_ack, 32'(c % 2 == 0));
         if (c % 2 == 1) begin
            chk($sformatf("b2b_mem_en_c%0d", c), bus.mem_en, 1);
            chk($sformatf("b2b_mem_addr_c%0d", c), bus.mem_addr, {SPACE_I, b2b_addr[k]});
         end else begin
            chk($sformatf("b2b_i_data_c%0d", c), bus.i_data, ref_mem[{SPACE_I, b2b_addr[k]}]);
            k++;
            if (k > 3) k = 3;
         end
      end
      @(posedge clk); #1;
      clr_in();
      repeat (2) @(posedge clk);

      // Randomized run against the reference model
      busy = 0; losses = 0;
      i_pend = 1'b0; d_pend = 1'b0;
      ack_i_cur = 1'b0; ack_d_cur = 1'b0; chk_rd_cur = 1'b0; exp_rd_cur = '0;
      err_cur = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         if (!i_pend && $urandom_range(0, 2) != 0) begin
            i_pend     = 1'b1;
            bus.i_addr = AW'($urandom_range(0, 4095));
         end
         bus.i_req = i_pend;
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            d_pend        = 1'b1;
            op            = int'($urandom_range(0, 15));
            bus.d_rd      = (op == 0) || (op >= 9);
            bus.d_wr      = (op == 0) || (op >= 2 && op < 9);
            bus.d_addr    = AW'($urandom_range(0, 15));
            bus.d_wr_data = DW'($urandom);
         end
         bus.d_en = d_pend;

         issue = 1'b0; ack_i_nxt = 1'b0; ack_d_nxt = 1'b0;
         chk_rd_nxt = 1'b0; exp_rd_nxt = '0; e_we = 1'b0; e_addr = '0;
         err_nxt = err_cur;
         if (busy == 0) begin
            if (i_pend || d_pend) begin
               issue = 1'b1;
               win_i = i_pend && (!d_pend || losses == MW);
               if (win_i) begin
                  e_addr     = {SPACE_I, bus.i_addr};
                  losses     = 0;
                  ack_i_nxt  = 1'b1;
                  chk_rd_nxt = 1'b1;
                  exp_rd_nxt = ref_mem[e_addr];
               end else begin
                  e_addr     = {SPACE_D, bus.d_addr};
                  e_we       = bus.d_wr && !bus.d_rd;
                  losses     = i_pend ? ((losses < MW) ? losses + 1 : MW) : 0;
                  ack_d_nxt  = 1'b1;
                  chk_rd_nxt = !e_we;
                  exp_rd_nxt = ref_mem[e_addr];
                  if (bus.d_rd && bus.d_wr) err_nxt = 1'b1;
                  if (e_we) ref_mem[e_addr] = bus.d_wr_data;
               end
            end else begin
               losses = 0;
            end
         end

         @(negedge clk);
         chk("rnd_mem_en", bus.mem_en, issue);
         if (issue) begin
            chk("rnd_mem_addr", bus.mem_addr, e_addr);
            chk("rnd_mem_we", bus.mem_we, e_we);
            if (e_we) chk("rnd_mem_wdata", bus.mem_wdata, bus.d_wr_data);
         end
         chk("rnd_i_ack", bus.i_ack, ack_i_cur);
         chk("rnd_d_ack", bus.d_ack, ack_d_cur);
         if (ack_i_cur && chk_rd_cur) chk("rnd_i_data", bus.i_data, exp_rd_cur);
         if (ack_d_cur && chk_rd_cur) chk("rnd_d_rd_data", bus.d_rd_data, exp_rd_cur);
         chk("rnd_err", bus.err_conflict, err_cur);
         if (ack_i_cur) i_pend = 1'b0;
         if (ack_d_cur) d_pend = 1'b0;

         busy       = int'(issue);
         ack_i_cur  = ack_i_nxt;
         ack_d_cur  = ack_d_nxt;
         chk_rd_cur = chk_rd_nxt;
         exp_rd_cur = exp_rd_nxt;
         err_cur    = err_nxt;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
